// File: rtl/arb_mux_nto1.sv
`default_nettype none
// ============================================================================
//  Module   : arb_mux_nto1
//  Brief    : Registered, round-robin arbitrated N-to-1 valid/ready
//             multiplexer. SIZE input channels of WIDTH bits feed a single
//             entry output register; the channel index travels with the word.
//             Optional packet locking is built when ARB_MUX_LOCK_EN is
//             defined (holds the grant on one channel until its in_last beat).
//  Revision : 1.0 - initial release
// ============================================================================
module arb_mux_nto1 #(
   parameter  int WIDTH = 1,
   parameter  int SIZE  = 4,
   // Bits needed to encode channel indices 0..SIZE-1.
   localparam int SELW  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [WIDTH*SIZE-1:0] in_data,
   input  logic [SIZE-1:0]       in_valid,
   input  logic [SIZE-1:0]       in_last,
   output logic [SIZE-1:0]       in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SELW-1:0]       out_sel,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam logic [SELW-1:0] c_LAST_CH = SELW'(SIZE - 1);

   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_sel;
   logic             r_out_last;
   logic             r_out_valid;
   logic [SELW-1:0]  r_ptr;

   logic             w_load;
   logic             w_found;
   logic             w_xfer;
   logic [SELW-1:0]  w_grant;
   logic [SELW-1:0]  w_next_ptr;
   logic [SIZE-1:0]  w_elig;
   logic [WIDTH-1:0] w_data;
   logic             w_last;

   // The output register can take a new word when empty or draining this cycle.
   assign w_load = !r_out_valid || out_ready;
   assign w_xfer = w_load && w_found;

   // Explicit wrap so non-power-of-2 SIZE never points past the last channel.
   assign w_next_ptr = (w_grant == c_LAST_CH) ? '0 : w_grant + 1'b1;

`ifdef ARB_MUX_LOCK_EN
   logic            r_locked;
   logic [SELW-1:0] r_lock_ch;

   // While a packet is in flight only its channel may compete.
   always_comb begin
      w_elig = in_valid;
      if (r_locked) begin
         w_elig            = '0;
         w_elig[r_lock_ch] = in_valid[r_lock_ch];
      end
   end
`else
   assign w_elig = in_valid;
`endif

   // Round-robin search: lowest eligible index at or above ptr wins,
   // otherwise the lowest eligible index overall (the wrapped region).
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      for (int j = SIZE - 1; j >= 0; j--) begin
         if (w_elig[j]) begin
            w_found = 1'b1;
            w_grant = SELW'(j);
         end
      end
      for (int j = SIZE - 1; j >= 0; j--) begin
         if (w_elig[j] && (SELW'(j) >= r_ptr)) begin
            w_grant = SELW'(j);
         end
      end
   end

   // Select the granted channel's word and end-of-packet flag.
   always_comb begin
      w_data = '0;
      w_last = 1'b0;
      for (int j = 0; j < SIZE; j++) begin
         if (w_grant == SELW'(j)) begin
            w_data = in_data[j*WIDTH +: WIDTH];
            w_last = in_last[j];
         end
      end
   end

   // One-hot accept to the granted channel only when the register can load.
   always_comb begin
      in_ready = '0;
      for (int j = 0; j < SIZE; j++) begin
         if (w_xfer && (w_grant == SELW'(j))) begin
            in_ready[j] = 1'b1;
         end
      end
   end

   // Output register: capture on transfer, empty when loading with no grant.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         if (w_found) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_sel   <= w_grant;
            r_out_last  <= w_last;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef ARB_MUX_LOCK_EN
   // Pointer and lock: a non-last beat locks onto its channel and freezes
   // the pointer; the last beat unlocks and moves the pointer past it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr     <= '0;
         r_locked  <= 1'b0;
         r_lock_ch <= '0;
      end else if (w_xfer) begin
         if (w_last) begin
            r_locked <= 1'b0;
            r_ptr    <= w_next_ptr;
         end else begin
            r_locked  <= 1'b1;
            r_lock_ch <= w_grant;
         end
      end
   end
`else
   // Word-level round robin: the pointer moves past every granted channel.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= '0;
      end else if (w_xfer) begin
         r_ptr <= w_next_ptr;
      end
   end
`endif

   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
   assign out_last  = r_out_last;
   assign out_valid = r_out_valid;

endmodule
`default_nettype wire
